// File: rtl/decrypt_sched_if.sv
// rtl/decrypt_sched_if.sv - requester, pipeline and result signals of decrypt_sched
// master is the requester/pipeline side, slave is the scheduler.
interface decrypt_sched_if #(
  parameter int N = 256
);
  logic         in0_valid;
  logic         in0_ready;
  logic [N-1:0] in0_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [N-1:0] in1_data;
  logic [N-1:0] key0;
  logic [N-1:0] key1;
  logic [N-1:0] dec_e_data;
  logic [N-1:0] dec_key;
  logic [N-1:0] dec_data;
  logic         out_valid;
  logic         out_ch;
  logic [N-1:0] out_data;
  logic         busy;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, key0, key1, dec_data,
    output in0_ready, in1_ready, dec_e_data, dec_key, out_valid, out_ch, out_data, busy
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, key0, key1, dec_data,
    input  in0_ready, in1_ready, dec_e_data, dec_key, out_valid, out_ch, out_data, busy
  );
endinterface

// File: rtl/decrypt_sched.sv
// rtl/decrypt_sched.sv - two-channel scheduler and key sequencer for the decryption pipeline
// Stalls issue for a key-settle window after each key load and tags results by channel.
module decrypt_sched #(
  parameter int N         = 256,
  parameter int LAT       = 4,
  parameter int KEY_SETUP = 9,
  parameter int MAX_BURST = 8
) (
  input logic            clock,
  input logic            reset_n,
  decrypt_sched_if.slave bus
);

  localparam int SW = $clog2(KEY_SETUP + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(KEY_SETUP);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(1);
  localparam logic [BW-1:0] BURST_MAX   = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [N-1:0]  key_q, key_d;
  logic [LAT:0]  tag_v_q, tag_v_d;
  logic [LAT:0]  tag_ch_q, tag_ch_d;
  logic          out_valid_q, out_valid_d;
  logic          out_ch_q, out_ch_d;
  logic [N-1:0]  out_data_q, out_data_d;

  logic          own_valid;
  logic          oth_valid;
  logic [N-1:0]  own_data;
  logic          switch_req;
  logic          own_ready;
  logic          accept;
  logic          winner;

  // A waiting other channel pre-empts the owner once it idles or exhausts its burst.
  always_comb begin
    own_valid  = owner_q ? bus.in1_valid : bus.in0_valid;
    oth_valid  = owner_q ? bus.in0_valid : bus.in1_valid;
    own_data   = owner_q ? bus.in1_data  : bus.in0_data;
    switch_req = (state_q == RUN) && oth_valid && (!own_valid || (burst_q == BURST_MAX));
    own_ready  = (state_q == RUN) && !switch_req;
    accept     = own_ready && own_valid;
    winner     = (bus.in0_valid && bus.in1_valid) ? rr_q : bus.in1_valid;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    settle_d = settle_q;
    burst_d  = burst_q;
    key_d    = key_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in0_valid || bus.in1_valid) begin
          key_d    = winner ? bus.key1 : bus.key0;
          owner_d  = winner;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == SETTLE_LAST) begin
          state_d = RUN;
          burst_d = '0;
        end
      end
      RUN: begin
        if (switch_req) begin
          key_d    = owner_q ? bus.key0 : bus.key1;
          owner_d  = !owner_q;
          rr_d     = owner_q;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end else if (accept && (burst_q != BURST_MAX)) begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tags ride alongside the pipeline; depth LAT marks the cycle dec_data is valid.
  always_comb begin
    tag_v_d     = {tag_v_q[LAT-1:0], accept};
    tag_ch_d    = {tag_ch_q[LAT-1:0], accept && owner_q};
    out_valid_d = tag_v_q[LAT];
    out_ch_d    = tag_ch_q[LAT];
    out_data_d  = tag_v_q[LAT] ? bus.dec_data : out_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      settle_q    <= '0;
      burst_q     <= '0;
      key_q       <= '0;
      tag_v_q     <= '0;
      tag_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      settle_q    <= settle_d;
      burst_q     <= burst_d;
      key_q       <= key_d;
      tag_v_q     <= tag_v_d;
      tag_ch_q    <= tag_ch_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in0_ready  = own_ready && !owner_q;
  assign bus.in1_ready  = own_ready && owner_q;
  assign bus.dec_e_data = accept ? own_data : '0;
  assign bus.dec_key    = key_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = (state_q != IDLE) || (|tag_v_q);

endmodule

// File: tb/tb_decrypt_sched.sv
// tb/tb_decrypt_sched.sv - randomized bench for decrypt_sched against a behavioural scoreboard
// Includes a stand-in 5-stage pipeline whose key path lags the data path by 5 edges.
module tb_decrypt_sched;
  localparam int N         = 256;
  localparam int LAT       = 4;
  localparam int KEY_SETUP = 9;
  localparam int MAX_BURST = 8;

  logic clock;
  logic reset_n;

  decrypt_sched_if #(.N(N)) bus();

  decrypt_sched #(
    .N(N), .LAT(LAT), .KEY_SETUP(KEY_SETUP), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  bit ch_log[$];

  function automatic logic [N-1:0] decrypt(input logic [N-1:0] c, input logic [N-1:0] k);
    return (c ^ {k[N/2-1:0], k[N-1:N/2]}) - k;
  endfunction

  function automatic logic [N-1:0] rnd_blk();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Pipeline stand-in: block sampled at edge t pairs with dec_key sampled at edge t-5.
  logic [N-1:0] pd [4];
  logic [N-1:0] pk [9];
  logic [N-1:0] pipe_out;
  always @(posedge clock) begin
    pd[0] <= bus.dec_e_data;
    for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
    pk[0] <= bus.dec_key;
    for (int i = 1; i < 9; i++) pk[i] <= pk[i-1];
    pipe_out <= decrypt(pd[3], pk[8]);
  end
  assign bus.dec_data = pipe_out;

  // Behavioural model: owner, the edge from which it may issue, and expected results.
  typedef struct {
    int unsigned  due;
    bit           ch;
    logic [N-1:0] pt;
  } res_t;

  int unsigned  cyc;
  bit           m_active, m_owner, m_rr;
  int unsigned  m_ready_at;
  int           m_burst;
  logic [N-1:0] m_key;
  res_t         exp_q[$];
  bit           m_out_valid, m_out_ch;
  logic [N-1:0] m_out_data;

  function automatic void model_comb(output bit rdy0, output bit rdy1, output bit acc, output bit sw);
    bit run, ov, xv;
    run  = m_active && (cyc + 1 >= m_ready_at);
    ov   = m_owner ? bus.in1_valid : bus.in0_valid;
    xv   = m_owner ? bus.in0_valid : bus.in1_valid;
    sw   = run && xv && (!ov || m_burst == MAX_BURST);
    rdy0 = run && !sw && !m_owner;
    rdy1 = run && !sw && m_owner;
    acc  = (rdy0 && bus.in0_valid) || (rdy1 && bus.in1_valid);
  endfunction

  function automatic void model_reset();
    m_active = 0; m_owner = 0; m_rr = 0; m_burst = 0; m_ready_at = 0;
    m_key = '0; exp_q.delete();
    m_out_valid = 0; m_out_ch = 0; m_out_data = '0;
  endfunction

  function automatic void model_step();
    bit r0, r1, acc, sw, win;
    res_t r;
    model_comb(r0, r1, acc, sw);
    cyc++;
    if (!m_active) begin
      if (bus.in0_valid || bus.in1_valid) begin
        win        = (bus.in0_valid && bus.in1_valid) ? m_rr : bus.in1_valid;
        m_owner    = win;
        m_key      = win ? bus.key1 : bus.key0;
        m_active   = 1;
        m_ready_at = cyc + KEY_SETUP + 1;
        m_burst    = 0;
      end
    end else if (sw) begin
      m_owner    = !m_owner;
      m_key      = m_owner ? bus.key1 : bus.key0;
      m_rr       = !m_owner;
      m_ready_at = cyc + KEY_SETUP + 1;
      m_burst    = 0;
    end else if (acc) begin
      r.due = cyc + LAT + 1;
      r.ch  = m_owner;
      r.pt  = decrypt(m_owner ? bus.in1_data : bus.in0_data, m_key);
      exp_q.push_back(r);
      if (m_burst < MAX_BURST) m_burst++;
    end
    m_out_valid = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      m_out_valid = 1;
      m_out_ch    = exp_q[0].ch;
      m_out_data  = exp_q[0].pt;
      void'(exp_q.pop_front());
    end
  endfunction

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    bit r0, r1, acc, sw;
    logic [N-1:0] e;
    forever begin
      @(negedge clock);
      model_comb(r0, r1, acc, sw);
      e = acc ? (m_owner ? bus.in1_data : bus.in0_data) : '0;
      chk("in0_ready", bus.in0_ready, r0);
      chk("in1_ready", bus.in1_ready, r1);
      chk("dec_e_data", bus.dec_e_data, e);
      chk("dec_key", bus.dec_key, m_key);
      chk("busy", bus.busy, m_active || (exp_q.size() > 0));
      chk("out_valid", bus.out_valid, m_out_valid);
      chk("out_data", bus.out_data, m_out_data);
      if (m_out_valid) chk("out_ch", bus.out_ch, m_out_ch);
      if (bus.out_valid) begin
        out_cnt++;
        ch_log.push_back(bus.out_ch);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input bit v0, input bit v1);
    bus.in0_valid = v0;
    bus.in1_valid = v1;
    bus.in0_data  = rnd_blk();
    bus.in1_data  = rnd_blk();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_in0_ready", bus.in0_ready, 0);
    chk("rst_in1_ready", bus.in1_ready, 0);
    chk("rst_dec_key", bus.dec_key, 0);
    chk("rst_dec_e_data", bus.dec_e_data, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Holds the given valids until n accepts land on channel ch; lat is the first accept cycle.
  task automatic stream(input bit v0, input bit v1, input bit ch, input int n, output int lat);
    int cnt;
    cnt = 0;
    lat = -1;
    for (int i = 0; i < 100 && cnt < n; i++) begin
      set_in(v0, v1);
      #1;
      if (ch ? (bus.in1_ready && bus.in1_valid) : (bus.in0_ready && bus.in0_valid)) begin
        if (lat < 0) lat = i;
        cnt++;
      end
      step();
    end
    chk("stream_accepts", cnt, n);
  endtask

  initial begin
    int lat, p0, p1;
    reset_n  = 1'b0;
    bus.key0 = '0;
    bus.key1 = '0;
    set_in(0, 0);
    chk("model_decrypt_pin", decrypt(256'h0F, 256'h1), (256'd1 << 128) + 256'hE);
    step();
    pulse_reset();

    // ch0 alone, 3 blocks under key K
    bus.key0 = rnd_blk();
    out_cnt  = 0;
    stream(1, 0, 0, 3, lat);
    set_in(0, 0);
    chk("first_ready_latency", lat, 10);
    repeat (12) step();
    chk("ch0_result_count", out_cnt, 3);

    // idle in RUN, then resume under a changed key0 without settling
    repeat (20) step();
    bus.key0 = rnd_blk();
    set_in(1, 0);
    #1;
    chk("resume_ready", bus.in0_ready, 1);
    step();
    set_in(0, 0);
    repeat (8) step();

    // both channels valid continuously from IDLE
    pulse_reset();
    ch_log.delete();
    bus.key0 = rnd_blk();
    bus.key1 = rnd_blk();
    repeat (70) begin
      set_in(1, 1);
      step();
    end
    set_in(0, 0);
    repeat (12) step();
    if (ch_log.size() < 16) chk("burst_log_size", ch_log.size(), 16);
    else for (int i = 0; i < 16; i++) chk("burst_ch_pattern", ch_log[i], (i < 8) ? 0 : 1);

    // ch0 stops after 2 blocks while ch1 waits
    pulse_reset();
    bus.key0 = rnd_blk();
    bus.key1 = rnd_blk();
    stream(1, 1, 0, 2, lat);
    repeat (30) begin
      set_in(0, 1);
      step();
    end
    set_in(0, 0);
    repeat (10) step();

    // reset with 4 blocks in flight
    pulse_reset();
    bus.key0 = rnd_blk();
    stream(1, 0, 0, 4, lat);
    set_in(0, 0);
    out_cnt = 0;
    pulse_reset();
    repeat (12) step();
    chk("no_out_after_reset", out_cnt, 0);

    // randomized traffic with fresh keys every cycle and occasional resets
    for (int blk = 0; blk < 50; blk++) begin
      p0 = $urandom_range(0, 100);
      p1 = $urandom_range(0, 100);
      if ($urandom_range(0, 9) == 0) begin
        set_in(0, 0);
        pulse_reset();
      end
      repeat (60) begin
        bus.key0 = rnd_blk();
        bus.key1 = rnd_blk();
        set_in($urandom_range(0, 99) < p0, $urandom_range(0, 99) < p1);
        step();
      end
    end
    set_in(0, 0);
    repeat (15) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decrypt_sched.md
# decrypt_sched

Two-channel scheduler and key sequencer for the 256-bit, 5-stage decryption pipeline. It arbitrates between two ciphertext requesters and drives the pipeline's `e_data`/`key` inputs. The pipeline's key path is delayed by 9 registers against a 4-register data path, so before issuing under a new key the block holds off for a key-settle window. It tags each issued block with its channel and re-registers the pipeline output as a valid-qualified, channel-tagged result stream.

## Interface
- `N`, 256: data/key width.
- `LAT`, 4: clock edges from the edge sampling `dec_e_data` to the first edge at which `dec_data` holds that block's plaintext.
- `KEY_SETUP`, 9: stall cycles after a `dec_key` change before the first issue under it. Must be ≥5.
- `MAX_BURST`, 8: maximum consecutive accepts for one owner while the other channel waits.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in0_valid` / `in1_valid`  in  1  request valid per channel.
- `in0_ready` / `in1_ready`  out  1  accept (combinational from state, owner, `burst_cnt`).
- `in0_data` / `in1_data`  in  N  ciphertext block.
- `key0` / `key1`  in  N  per-channel key. Sampled only at a key load.
- `dec_e_data`  out  N  to pipeline `e_data`: accepted block, else 0.
- `dec_key`  out  N  to pipeline `key`, registered.
- `dec_data`  in  N  from pipeline `data`.
- `out_valid`  out  1  result strobe.
- `out_ch`  out  1  channel of result.
- `out_data`  out  N  plaintext, registered.
- `busy`  out  1  state ≠ IDLE or any tag in flight.

## Operation
- States: IDLE, SETTLE, RUN. Registers: `owner`, `rr_ptr`, `settle_cnt`, `burst_cnt`, tag shift register of depth LAT+1 (valid, ch).
- IDLE, both `inX_ready` = 0.
  - Any `inX_valid`: winner is the sole requester, else channel `rr_ptr`.
  - Load `dec_key` ← `key[winner]`, `owner` ← winner, `settle_cnt` ← KEY_SETUP.
  - Go to SETTLE.
- SETTLE, both ready = 0. Decrement `settle_cnt` each cycle; at 1, go to RUN with `burst_cnt` = 0.
- RUN:
  - `in[owner]_ready` = 1 unless a switch is pending. Other channel's ready = 0.
  - Accept (`valid` & `ready`): `dec_e_data` = `in[owner]_data`, push tag {1, owner}, `burst_cnt`++ (saturating at MAX_BURST).
  - Switch pending when `in[!owner]_valid` and (`!in[owner]_valid` or `burst_cnt` == MAX_BURST).
    - Ready is 0 that cycle.
    - Load `dec_key` ← `key[!owner]`, `owner` ← !owner, `rr_ptr` ← !new owner, `settle_cnt` ← KEY_SETUP.
    - Go to SETTLE.
  - Neither channel valid: stay in RUN, key retained, no settle on resume by the same owner.
- Blocks already in flight keep their key: the pipeline consumed their key sample before any later change. No drain is required on a switch.
- Result path:
  - Tag at depth LAT qualifies `dec_data`.
  - Next edge: `out_valid` ← tag.valid, `out_ch` ← tag.ch, `out_data` ← `dec_data` (`out_data` retains when not valid).
- `inX_data` / `keyX` are unconstrained when not sampled.

## Timing
- Reset (async assert, sync release): IDLE, `owner` = 0, `rr_ptr` = 0, counters 0, tags cleared.
  - All outputs 0: `dec_key`, `dec_e_data`, `out_*`, readys, `busy`.
  - Mid-operation reset discards in-flight tags; no `out_valid` follows.
- Key load at edge E: SETTLE occupies the cycles after edges E … E+KEY_SETUP−1. The first accept is sampled at edge E+KEY_SETUP+1 at earliest.
- Block accepted at edge t:
  - `out_valid` = 1 in the cycle after edge t+LAT+1 (6 edges by default).
  - Results return in issue order, one per cycle at full rate.
- Throughput: 1 block/cycle in RUN. Each owner change costs 1 switch cycle + KEY_SETUP cycles.
- Simultaneous valid in IDLE: `rr_ptr` decides (channel 0 after reset).
- `burst_cnt` saturates; it matters only when the other channel is waiting.

## Test plan
- Reset, ch0 streams 3 blocks, key0 = K: first ready 10 cycles after valid. `out_valid` ×3, `out_ch` = 0, plaintext matches the reference decrypt of K, 6 cycles after each accept.
- Both valid continuously from IDLE: 8 ch0 accepts, switch, 9 stall cycles, 8 ch1 accepts, repeat. `out_ch` pattern 0×8, 1×8.
- ch0 stops after 2 blocks while ch1 is valid: immediate switch. Both ch0 results are correct despite `dec_key` changing while they are in flight.
- ch0 idles 20 cycles in RUN, then resumes: accepted on the first valid cycle, no settle.
- `reset_n` pulsed low with 4 blocks in flight: all outputs 0 immediately, no `out_valid` afterwards, `busy` = 0.
- `key0` changed during RUN for ch0: results still use the previously loaded key until the next load.
